// File: rtl/orv64_inst_fetch_buf_if.sv
// Fetch-side bundle between the fetch buffer, instruction memory, back end and decode.
// Latency: wires only; request/response timing is owned by the fetch buffer.
// Backpressure: decode throttles with id_ready; memory stalls by returning inst_miss.
interface orv64_inst_fetch_buf_if #(
  parameter int PC_WIDTH = 64
);
  // memory request / response
  logic [PC_WIDTH-1:0] pc;
  logic                inst_re;
  logic [31:0]         inst;
  logic                inst_miss;
  // back-end redirect
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  // decode handshake
  logic                if_valid;
  logic [PC_WIDTH-1:0] if_pc;
  logic [31:0]         if_inst;
  logic                id_ready;

  // fetch buffer side
  modport master (
    output pc, inst_re, if_valid, if_pc, if_inst,
    input  inst, inst_miss, redirect_valid, redirect_pc, id_ready
  );

  // memory / back end / decode side
  modport slave (
    input  pc, inst_re, if_valid, if_pc, if_inst,
    output inst, inst_miss, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/orv64_inst_fetch_buf.sv
// Sequential fetch PC generator with miss retry and a small PC/instruction queue to decode.
// Latency: first instruction visible three edges after reset release; 1 inst/cycle steady state.
// Backpressure: stops issuing when queue plus in-flight request would exceed FIFO_DEPTH.
module orv64_inst_fetch_buf #(
  parameter int FIFO_DEPTH = 4,
  parameter int PC_WIDTH   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] rst_pc,
  orv64_inst_fetch_buf_if.master bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] req_pc;
  logic [PC_WIDTH-1:0] pc_q;
  logic                req_pending;
  logic [CNT_W-1:0]    count;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PC_WIDTH-1:0] mem_pc   [FIFO_DEPTH];
  logic [31:0]         mem_inst [FIFO_DEPTH];

  logic             in_run;
  logic             redir;
  logic             retry;
  logic             new_req;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] occupancy;
  logic [PC_WIDTH-1:0] pc_nxt;

  // Request/response decisions for the current cycle; redirect overrides retry and pop.
  always_comb begin
    in_run    = (state == RUN);
    redir     = in_run & bus.redirect_valid;
    retry     = in_run & ~redir & req_pending & bus.inst_miss;
    // Credit check uses the count before this cycle's pop so a freed slot is not reused early.
    occupancy = count + CNT_W'(req_pending);
    new_req   = in_run & ~redir & ~retry & (occupancy < CNT_W'(FIFO_DEPTH));
    push      = req_pending & ~bus.inst_miss & ~redir;
    pop       = bus.if_valid & bus.id_ready;
    pc_nxt    = retry ? req_pc : (new_req ? fetch_pc : pc_q);
  end

  assign bus.pc       = pc_nxt;
  assign bus.inst_re  = retry | new_req;
  assign bus.if_valid = (count != '0) & ~bus.redirect_valid;
  assign bus.if_pc    = mem_pc[rd_ptr];
  assign bus.if_inst  = mem_inst[rd_ptr];

  // Boot/run control, fetch PC, in-flight request tracking and queue pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetch_pc    <= '0;
      req_pc      <= '0;
      pc_q        <= '0;
      req_pending <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      pc_q <= pc_nxt;
      if (state == BOOT) begin
        fetch_pc <= {rst_pc[PC_WIDTH-1:2], 2'b00};
        state    <= RUN;
      end else if (redir) begin
        // Everything queued or in flight belongs to the old path.
        fetch_pc    <= {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
        req_pending <= 1'b0;
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (new_req) begin
          req_pc      <= fetch_pc;
          fetch_pc    <= fetch_pc + PC_WIDTH'(4);
          req_pending <= 1'b1;
        end else if (!retry) begin
          req_pending <= 1'b0;
        end
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Queue storage: accepted responses are written with the PC they were fetched from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (push) begin
      mem_pc[wr_ptr]   <= req_pc;
      mem_inst[wr_ptr] <= bus.inst;
    end
  end

  a_pc_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    bus.inst_re |-> (bus.pc[1:0] == 2'b00));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (count != CNT_W'(FIFO_DEPTH)));

  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.if_valid && !bus.id_ready) |=>
      (!bus.if_valid || ($stable(bus.if_pc) && $stable(bus.if_inst))));
endmodule

// File: tb/tb_orv64_inst_fetch_buf.sv
module tb_orv64_inst_fetch_buf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] rst_pc;

  orv64_inst_fetch_buf_if #(.PC_WIDTH(64)) bus ();

  orv64_inst_fetch_buf #(.FIFO_DEPTH(DEPTH), .PC_WIDTH(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rst_pc (rst_pc),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of instructions decode is owed, plus the fetch stream position.
  ent_t        q[$];
  bit          boot;
  bit          prev_re;
  logic [63:0] prev_pc;
  logic [63:0] next_req;
  logic [63:0] last_pc;
  int          miss_pct;
  logic [63:0] miss_pc;
  int          miss_left;
  int          cyc;
  int          first_valid_cyc;
  logic [63:0] req_log[$];
  logic [63:0] deliv[$];
  logic        s_re, s_valid;
  logic [63:0] s_pc, s_ifpc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_deliv(input string name, input int idx, input logic [63:0] exp);
    chk(name, (idx < deliv.size()) ? deliv[idx] : 64'hDEAD_DEAD_DEAD_DEAD, exp);
  endtask

  task automatic chk_req(input string name, input int idx, input logic [63:0] exp);
    chk(name, (idx < req_log.size()) ? req_log[idx] : 64'hDEAD_DEAD_DEAD_DEAD, exp);
  endtask

  // One clock cycle: drive the memory response, check every output against the model, advance.
  task automatic step();
    logic        miss;
    logic        exp_valid, exp_re, pop;
    logic [63:0] exp_pc;
    ent_t        e;
    miss = 1'b0;
    if (prev_re) begin
      if (prev_pc == miss_pc && miss_left > 0) begin
        miss = 1'b1;
        miss_left--;
      end else begin
        miss = (int'($urandom_range(99)) < miss_pct);
      end
      bus.inst = mem_word(prev_pc);
    end else begin
      bus.inst = $urandom;
    end
    bus.inst_miss = miss;
    #1;
    exp_valid = (q.size() != 0) && !bus.redirect_valid;
    chk("if_valid", bus.if_valid, exp_valid);
    if (exp_valid) begin
      chk("if_pc", bus.if_pc, q[0].pc);
      chk("if_inst", bus.if_inst, q[0].inst);
    end
    exp_re = 1'b0;
    exp_pc = last_pc;
    if (!boot && !bus.redirect_valid) begin
      if (prev_re && miss) begin
        exp_re = 1'b1;
        exp_pc = prev_pc;
      end else if (q.size() + int'(prev_re) < DEPTH) begin
        exp_re = 1'b1;
        exp_pc = next_req;
      end
    end
    chk("inst_re", bus.inst_re, exp_re);
    chk("pc", bus.pc, exp_pc);
    s_re = bus.inst_re; s_pc = bus.pc; s_valid = bus.if_valid; s_ifpc = bus.if_pc;
    if (bus.inst_re) req_log.push_back(bus.pc);
    if (bus.if_valid && bus.id_ready) deliv.push_back(bus.if_pc);
    if (bus.if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    pop = exp_valid && bus.id_ready;
    if (boot) begin
      next_req = rst_pc & ~64'h3;
      boot = 1'b0;
    end else if (bus.redirect_valid) begin
      q.delete();
      next_req = bus.redirect_pc & ~64'h3;
    end else begin
      if (prev_re && !miss) begin
        e.pc = prev_pc;
        e.inst = mem_word(prev_pc);
        q.push_back(e);
      end
      if (pop) void'(q.pop_front());
      if (exp_re && !(prev_re && miss)) next_req = next_req + 64'd4;
    end
    prev_re = exp_re;
    prev_pc = exp_pc;
    last_pc = exp_pc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic [63:0] rpc);
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.inst_miss = 1'b0;
    #1;
    chk("reset pc", bus.pc, 64'h0);
    chk("reset inst_re", bus.inst_re, 1'b0);
    chk("reset if_valid", bus.if_valid, 1'b0);
    chk("reset if_pc", bus.if_pc, 64'h0);
    chk("reset if_inst", bus.if_inst, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_pc = rpc;
    rst_n = 1'b1;
    q.delete();
    boot = 1'b1; prev_re = 1'b0; prev_pc = '0; last_pc = '0; next_req = '0;
    miss_left = 0; miss_pct = 0; miss_pc = '1;
    cyc = 0; first_valid_cyc = -1;
    req_log.delete(); deliv.delete();
  endtask

  task automatic redirect_to(input logic [63:0] rpc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = rpc;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (n_cmp %0d)", n_cmp);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    rst_pc = '0;
    bus.inst = '0;
    bus.inst_miss = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b1;
    #2;

    // Boot and steady-state streaming.
    do_reset(64'h8000_0000);
    run(12);
    chk("boot first valid cycle", 64'(first_valid_cyc), 64'd3);
    chk_req("boot req0", 0, 64'h8000_0000);
    chk_req("boot req1", 1, 64'h8000_0004);
    chk_req("boot req2", 2, 64'h8000_0008);
    chk_deliv("boot deliv0", 0, 64'h8000_0000);
    chk_deliv("boot deliv1", 1, 64'h8000_0004);
    chk_deliv("boot deliv8", 8, 64'h8000_0020);

    // Miss retry on 0x8000_0004 for three response cycles.
    do_reset(64'h8000_0000);
    miss_pc = 64'h8000_0004;
    miss_left = 3;
    run(14);
    chk("retry count of 0x..04", 64'(req_log.find_index with (item == 64'h8000_0004).size()), 64'd4);
    chk_deliv("miss deliv0", 0, 64'h8000_0000);
    chk_deliv("miss deliv1", 1, 64'h8000_0004);
    chk_deliv("miss deliv2", 2, 64'h8000_0008);

    // Backpressure from decode.
    do_reset(64'h8000_0000);
    bus.id_ready = 1'b0;
    run(15);
    chk("bp request count", 64'(req_log.size()), 64'd4);
    chk("bp inst_re idle", s_re, 1'b0);
    chk("bp head held", s_ifpc, 64'h8000_0000);
    bus.id_ready = 1'b1;
    run(12);
    chk_deliv("bp deliv0", 0, 64'h8000_0000);
    chk_deliv("bp deliv3", 3, 64'h8000_000C);
    chk_deliv("bp deliv4", 4, 64'h8000_0010);

    // Redirect while retrying 0x8000_0008.
    do_reset(64'h8000_0000);
    miss_pc = 64'h8000_0008;
    miss_left = 10;
    run(6);
    deliv.delete();
    redirect_to(64'h1002);
    miss_left = 0;
    chk("redir cycle inst_re", s_re, 1'b0);
    chk("redir cycle if_valid", s_valid, 1'b0);
    step();
    chk("redir next inst_re", s_re, 1'b1);
    chk("redir next pc", s_pc, 64'h1000);
    run(8);
    chk_deliv("redir deliv0", 0, 64'h1000);
    chk_deliv("redir deliv1", 1, 64'h1004);

    // Address wrap-around.
    do_reset(64'h8000_0000);
    run(4);
    deliv.delete();
    redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
    run(10);
    chk_deliv("wrap deliv0", 0, 64'hFFFF_FFFF_FFFF_FFF8);
    chk_deliv("wrap deliv1", 1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk_deliv("wrap deliv2", 2, 64'h0);
    chk_deliv("wrap deliv3", 3, 64'h4);

    // Randomized traffic: decode stalls, misses and occasional redirects.
    do_reset(64'h0000_4000);
    miss_pct = 25;
    for (int i = 0; i < 3000; i++) begin
      bus.id_ready = ($urandom_range(3) != 0);
      if ($urandom_range(39) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = {$urandom, $urandom};
      end else begin
        bus.redirect_valid = 1'b0;
      end
      step();
    end
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b1;

    // Reset with three entries queued and a miss outstanding.
    do_reset(64'h8000_0000);
    bus.id_ready = 1'b0;
    for (int i = 0; i < 40 && q.size() < 3; i++) step();
    chk("mid-reset head valid", s_valid | bus.if_valid, 1'b1);
    miss_pct = 100;
    run(2);
    chk("mid-reset retrying", s_re, 1'b1);
    do_reset(64'h2000);
    bus.id_ready = 1'b1;
    run(8);
    chk_req("restart req0", 0, 64'h2000);
    chk_deliv("restart deliv0", 0, 64'h2000);
    chk_deliv("restart deliv1", 1, 64'h2004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
